// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with registered output, valid/ready handshake and multi-cycle MUL.
// Optional feature macro: ALUCTRL_ILLEGAL_TRAP_EN (undefined encodings trap as all-ones).
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 4,
  parameter int OPC_W      = 4,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [OPC_W-1:0]  opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              busy,
  output logic              illegal
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ill_q, ill_d;
  logic [1:0]        sync_q;
  logic              run;
  logic              accept;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_ill;
  logic              dec_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign run = sync_q[1];

  always_comb begin
    dec_ctrl = CTRL_W'(4'b0010);
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
    unique case (1'b1)
      alu_op == 2'b00: dec_ctrl = CTRL_W'(4'b0010);
      alu_op == 2'b01: dec_ctrl = CTRL_W'(4'b1010);
      alu_op == 2'b10: begin
        unique case (1'b1)
          funct == FUNCT_W'(4'b0010): dec_ctrl = CTRL_W'(4'b0010);
          funct == FUNCT_W'(4'b0011): dec_ctrl = CTRL_W'(4'b1010);
          funct == FUNCT_W'(4'b0000): dec_ctrl = CTRL_W'(4'b0000);
          funct == FUNCT_W'(4'b0001): dec_ctrl = CTRL_W'(4'b0001);
          funct == FUNCT_W'(4'b0100): dec_ctrl = CTRL_W'(4'b0011);
          funct == FUNCT_W'(4'b0111): dec_ctrl = CTRL_W'(4'b0110);
          default: begin
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
            dec_ctrl = '1;
            dec_ill  = 1'b1;
`else
            dec_ctrl = CTRL_W'(4'b0010);
`endif
          end
        endcase
      end
      default: begin
        unique case (1'b1)
          opcode == OPC_W'(4'b0001): dec_ctrl = CTRL_W'(4'b0010);
          opcode == OPC_W'(4'b0110): begin
            dec_ctrl = CTRL_W'(4'b0101);
            dec_mul  = 1'b1;
          end
          default: begin
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
            dec_ctrl = '1;
            dec_ill  = 1'b1;
`else
            dec_ctrl = CTRL_W'(4'b0010);
`endif
          end
        endcase
      end
    endcase
  end

  // Busy window is MUL_CYCLES-1 cycles so DONE lands MUL_CYCLES edges after accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    ill_d    = ill_q;
    in_ready = run & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    accept   = in_valid & in_ready;
    unique case (state_q)
      IDLE: ;
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ctrl_d = dec_ctrl;
      ill_d  = dec_ill;
      if (dec_mul && (MUL_CYCLES > 1)) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(MUL_CYCLES - 1);
      end else begin
        state_d = DONE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign alu_ctrl  = ctrl_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: reset, decode table, MUL timing,
// back-to-back, backpressure, reset mid-MUL and illegal encodings.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [3:0] funct;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       busy;
  logic       illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] ILL_CTRL = 4'b1111;
  localparam logic       ILL_FLAG = 1'b1;
`else
  localparam logic [3:0] ILL_CTRL = 4'b0010;
  localparam logic       ILL_FLAG = 1'b0;
`endif

  alu_ctrl_seq #(
    .FUNCT_W(4), .OPC_W(4), .CTRL_W(4), .MUL_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    alu_op = 2'b10; funct = 4'b0011; opcode = 4'b0000;
    step(); step();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || alu_ctrl !== 4'b0000 || illegal !== 1'b0)
      $display("FAIL reset_outputs: ov=%b busy=%b ctrl=%b ill=%b, want 0 0 0000 0",
               out_valid, busy, alu_ctrl, illegal);
    else pass_cnt++;
    rst_n = 1'b1; in_valid = 1'b0;
    step(); step(); step();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    in_valid = 1'b1; alu_op = 2'b10; funct = 4'b0011;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1010)
      $display("FAIL reset_first_op: ov=%b ctrl=%b want 1 1010", out_valid, alu_ctrl);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_drain: ov=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    logic [1:0] ops [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [3:0] fns [8] = '{4'h0, 4'h0, 4'h2, 4'h3, 4'h0, 4'h1, 4'h7, 4'h0};
    logic [3:0] opc [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    logic [3:0] exp [8] = '{4'b0010, 4'b1010, 4'b0010, 4'b1010,
                            4'b0000, 4'b0001, 4'b0110, 4'b0010};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; alu_op = ops[i]; funct = fns[i]; opcode = opc[i];
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || alu_ctrl !== exp[i] || illegal !== 1'b0)
        $display("FAIL decode_%0d: ov=%b ctrl=%b ill=%b want 1 %b 0",
                 i, out_valid, alu_ctrl, illegal, exp[i]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = 2'b11; opcode = 4'b0110;
    step();
    in_valid = 1'b1; alu_op = 2'b10; funct = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL mul_busy_%0d: busy=%b rdy=%b ov=%b want 1 0 0",
                 i, busy, in_ready, out_valid);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || alu_ctrl !== 4'b0101)
      $display("FAIL mul_done: ov=%b busy=%b ctrl=%b want 1 0 0101",
               out_valid, busy, alu_ctrl);
    else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mul_drain: ov=%b busy=%b want 0 0", out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] fns [3] = '{4'b0010, 4'b0011, 4'b0100};
    logic [3:0] exp [3] = '{4'b0010, 4'b1010, 4'b0011};
    out_ready = 1'b1; alu_op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; funct = fns[i];
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || alu_ctrl !== exp[i])
        $display("FAIL b2b_%0d: ov=%b ctrl=%b want 1 %b", i, out_valid, alu_ctrl, exp[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: ov=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 2'b10; funct = 4'b0001;
    step();
    alu_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_ctrl !== 4'b0001)
        $display("FAIL bp_hold_%0d: ov=%b rdy=%b ctrl=%b want 1 0 0001",
                 i, out_valid, in_ready, alu_ctrl);
      else pass_cnt++;
      step();
    end
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1010)
      $display("FAIL bp_next: ov=%b ctrl=%b want 1 1010", out_valid, alu_ctrl);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = 2'b11; opcode = 4'b0110;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || alu_ctrl !== 4'b0000)
      $display("FAIL rst_mul_async: busy=%b ov=%b ctrl=%b want 0 0 0000",
               busy, out_valid, alu_ctrl);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_mul_no_valid: got %0d active cycles want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = 2'b10; funct = 4'b1111;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_ctrl !== ILL_CTRL || illegal !== ILL_FLAG)
      $display("FAIL illegal_funct: ov=%b ctrl=%b ill=%b want 1 %b %b",
               out_valid, alu_ctrl, illegal, ILL_CTRL, ILL_FLAG);
    else pass_cnt++;
    step();
    in_valid = 1'b1; alu_op = 2'b11; opcode = 4'b1111;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_ctrl !== ILL_CTRL || illegal !== ILL_FLAG)
      $display("FAIL illegal_opcode: ov=%b ctrl=%b ill=%b want 1 %b %b",
               out_valid, alu_ctrl, illegal, ILL_CTRL, ILL_FLAG);
    else pass_cnt++;
    step();
    in_valid = 1'b1; alu_op = 2'b00;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (alu_ctrl !== 4'b0010 || illegal !== 1'b0)
      $display("FAIL illegal_clear: ctrl=%b ill=%b want 0010 0", alu_ctrl, illegal);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
